// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the fetch-stage program counter.
package pc_pkg;

    localparam int unsigned INSTR_BYTES   = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_EXC,
        SEL_BR,
        SEL_JMP,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/pc_if.sv
// Redirect/event inputs and fetch-address outputs of pc_unit.
// master = hazard/branch resolution side, slave = pc_unit.
interface pc_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              stall_i;
    logic              exc_i;
    logic [ADDR_W-1:0] exc_pc_i;
    logic              branch_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_target_i;
    logic              call_i;
    logic [ADDR_W-1:0] call_ret_i;
    logic              ret_i;
    logic [ADDR_W-1:0] ret_target_i;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc_plus4_o;
    logic              redirect_o;
    logic [ADDR_W-1:0] epc_o;
    logic [CNT_W-1:0]  ras_count_o;

    modport master (
        output stall_i, exc_i, exc_pc_i, branch_i, branch_target_i,
               jump_i, jump_target_i, call_i, call_ret_i, ret_i, ret_target_i,
        input  pc_o, pc_plus4_o, redirect_o, epc_o, ras_count_o
    );

    modport slave (
        input  stall_i, exc_i, exc_pc_i, branch_i, branch_target_i,
               jump_i, jump_target_i, call_i, call_ret_i, ret_i, ret_target_i,
        output pc_o, pc_plus4_o, redirect_o, epc_o, ras_count_o
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// push+pop together replaces the top in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [W-1:0]               push_data_i,
    output logic [W-1:0]               top_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ptr_q is the next free slot, so the top lives one below it
    assign top_idx = ptr_q - PTR_W'(1);
    assign top_o   = mem_q[top_idx];
    assign count_o = cnt_q;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i) begin
            mem_d[top_idx] = push_data_i;
        end else if (push_i) begin
            mem_d[ptr_q] = push_data_i;
            ptr_d        = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic  clk_i,
    input  logic  rst_i,
    pc_if.slave   bus
);
    localparam int unsigned       CNT_W      = $clog2(RAS_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_valid;

    always_comb begin
        sel = SEL_SEQ;
        if (bus.exc_i)         sel = SEL_EXC;
        else if (bus.branch_i) sel = SEL_BR;
        else if (bus.jump_i)   sel = SEL_JMP;
        else if (bus.ret_i)    sel = SEL_RET;
        else if (bus.stall_i)  sel = SEL_HOLD;
    end

`ifdef PC_RAS_EN
    logic             ras_push, ras_pop, ras_clear;
    logic [CNT_W-1:0] ras_count;

    // exc/branch in the same cycle mean the call/ret is on the wrong path
    assign ras_clear = bus.exc_i;
    assign ras_push  = bus.call_i && !bus.exc_i && !bus.branch_i && !bus.stall_i;
    assign ras_pop   = (sel == SEL_RET);
    assign ras_valid = (ras_count != '0);

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .clear_i     (ras_clear),
        .push_data_i (bus.call_ret_i),
        .top_o       (ras_top),
        .count_o     (ras_count)
    );

    assign bus.ras_count_o = ras_count;
`else
    logic unused_call;

    assign unused_call     = ^{bus.call_i, bus.call_ret_i};
    assign ras_top         = '0;
    assign ras_valid       = 1'b0;
    assign bus.ras_count_o = '0;
`endif

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        unique case (sel)
            SEL_EXC: pc_d = EXC_VEC & ALIGN_MASK;
            SEL_BR:  pc_d = bus.branch_target_i & ALIGN_MASK;
            SEL_JMP: pc_d = bus.jump_target_i & ALIGN_MASK;
            SEL_RET: pc_d = (ras_valid ? ras_top : bus.ret_target_i) & ALIGN_MASK;
            SEL_SEQ: pc_d = pc_q + ADDR_W'(INSTR_BYTES);
            default: pc_d = pc_q;
        endcase
        if (sel inside {SEL_EXC, SEL_BR, SEL_JMP, SEL_RET}) redirect_d = 1'b1;
        if (bus.exc_i) epc_d = bus.exc_pc_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_q + ADDR_W'(INSTR_BYTES);
    assign bus.redirect_o = redirect_q;
    assign bus.epc_o      = epc_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; RAS scenarios run when PC_RAS_EN is defined.
module tb_pc_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();

    pc_unit #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0),
        .EXC_VEC   (32'h0000_0080),
        .RAS_DEPTH (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall_i         = 1'b0;
        bus.exc_i           = 1'b0;
        bus.exc_pc_i        = '0;
        bus.branch_i        = 1'b0;
        bus.branch_target_i = '0;
        bus.jump_i          = 1'b0;
        bus.jump_target_i   = '0;
        bus.call_i          = 1'b0;
        bus.call_ret_i      = '0;
        bus.ret_i           = 1'b0;
        bus.ret_target_i    = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++;
        if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", bus.pc_o, 32'h0); end
        checks++;
        if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b want 0", bus.redirect_o); end
        checks++;
        if (bus.epc_o !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want 0", bus.epc_o); end
        checks++;
        if (bus.ras_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.ras_count_o); end
        checks++;
        if (bus.pc_plus4_o !== 32'h4) begin errors++; $display("FAIL reset_plus4 got %h want 4", bus.pc_plus4_o); end
        for (int i = 1; i <= 3; i++) begin
            cyc();
            checks++;
            if (bus.pc_o !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc_o, 32'(4 * i)); end
        end
        // reset wins over a simultaneous redirect
        bus.branch_i        = 1'b1;
        bus.branch_target_i = 32'h200;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h want 0", bus.pc_o); end
        checks++;
        if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL midrst_redirect got %b want 0", bus.redirect_o); end
    endtask

    task automatic test_stall_branch();
        repeat (4) cyc();
        checks++;
        if (bus.pc_o !== 32'h10) begin errors++; $display("FAIL pre_stall_pc got %h want 10", bus.pc_o); end
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (bus.pc_o !== 32'h10 || bus.redirect_o !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d] got pc=%h rd=%b want pc=10 rd=0", i, bus.pc_o, bus.redirect_o);
            end
        end
        bus.branch_i        = 1'b1;
        bus.branch_target_i = 32'h43;
        cyc();
        checks++;
        if (bus.pc_o !== 32'h40) begin errors++; $display("FAIL stall_branch_pc got %h want 40", bus.pc_o); end
        checks++;
        if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL stall_branch_redirect got %b want 1", bus.redirect_o); end
        clear_inputs();
        cyc();
        checks++;
        if (bus.pc_o !== 32'h44 || bus.redirect_o !== 1'b0) begin
            errors++; $display("FAIL post_branch got pc=%h rd=%b want pc=44 rd=0", bus.pc_o, bus.redirect_o);
        end
    endtask

    task automatic test_exception();
        bus.exc_i           = 1'b1;
        bus.exc_pc_i        = 32'h24;
        bus.branch_i        = 1'b1;
        bus.branch_target_i = 32'h300;
        bus.jump_i          = 1'b1;
        bus.jump_target_i   = 32'h400;
        bus.call_i          = 1'b1;
        bus.call_ret_i      = 32'h999;
        cyc();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h80) begin errors++; $display("FAIL exc_pc got %h want 80", bus.pc_o); end
        checks++;
        if (bus.epc_o !== 32'h24) begin errors++; $display("FAIL exc_epc got %h want 24", bus.epc_o); end
        checks++;
        if (bus.ras_count_o !== 3'd0) begin errors++; $display("FAIL exc_count got %0d want 0", bus.ras_count_o); end
        checks++;
        if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL exc_redirect got %b want 1", bus.redirect_o); end
        cyc();
        checks++;
        if (bus.pc_o !== 32'h84 || bus.epc_o !== 32'h24) begin
            errors++; $display("FAIL post_exc got pc=%h epc=%h want pc=84 epc=24", bus.pc_o, bus.epc_o);
        end
    endtask

    task automatic test_jump_wrap();
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'hFFFF_FFFF;
        cyc();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jump_pc got %h want fffffffc", bus.pc_o); end
        checks++;
        if (bus.pc_plus4_o !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h want 0", bus.pc_plus4_o); end
        cyc();
        checks++;
        if (bus.pc_o !== 32'h0 || bus.redirect_o !== 1'b0) begin
            errors++; $display("FAIL wrap_seq got pc=%h rd=%b want pc=0 rd=0", bus.pc_o, bus.redirect_o);
        end
    endtask

    task automatic test_ret_priority();
        bus.stall_i      = 1'b1;
        bus.ret_i        = 1'b1;
        bus.ret_target_i = 32'h2001;
        cyc();
        checks++;
        if (bus.pc_o !== 32'h2000 || bus.redirect_o !== 1'b1) begin
            errors++; $display("FAIL ret_over_stall got pc=%h rd=%b want pc=2000 rd=1", bus.pc_o, bus.redirect_o);
        end
        bus.stall_i       = 1'b0;
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'h3000;
        bus.ret_target_i  = 32'h4000;
        cyc();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h3000) begin errors++; $display("FAIL jump_over_ret got %h want 3000", bus.pc_o); end
    endtask

`ifndef PC_RAS_EN
    task automatic test_no_ras();
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'h600;
        bus.call_i        = 1'b1;
        bus.call_ret_i    = 32'h104;
        cyc();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h600 || bus.ras_count_o !== 3'd0) begin
            errors++; $display("FAIL noras_call got pc=%h cnt=%0d want pc=600 cnt=0", bus.pc_o, bus.ras_count_o);
        end
        bus.ret_i        = 1'b1;
        bus.ret_target_i = 32'h1234;
        cyc();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h1234) begin errors++; $display("FAIL noras_ret got %h want 1234", bus.pc_o); end
    endtask
`else
    task automatic test_ras_fill();
        logic [31:0] exp_pc [5];
        logic [2:0]  exp_cnt [5];
        exp_pc  = '{32'h504, 32'h404, 32'h304, 32'h204, 32'h7000};
        exp_cnt = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.jump_i        = 1'b1;
            bus.jump_target_i = 32'h1000;
            bus.call_i        = 1'b1;
            bus.call_ret_i    = 32'(32'h104 + 32'h100 * i);
            cyc();
            checks++;
            if (bus.ras_count_o !== 3'((i < 4) ? i + 1 : 4)) begin
                errors++; $display("FAIL ras_push_count[%0d] got %0d want %0d", i, bus.ras_count_o, (i < 4) ? i + 1 : 4);
            end
        end
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            bus.ret_i        = 1'b1;
            bus.ret_target_i = 32'h7000;
            cyc();
            checks++;
            if (bus.pc_o !== exp_pc[i] || bus.ras_count_o !== exp_cnt[i]) begin
                errors++; $display("FAIL ras_pop[%0d] got pc=%h cnt=%0d want pc=%h cnt=%0d",
                                   i, bus.pc_o, bus.ras_count_o, exp_pc[i], exp_cnt[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_call_ret_same();
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'h1000;
        bus.call_i        = 1'b1;
        bus.call_ret_i    = 32'h500;
        cyc();
        clear_inputs();
        bus.call_i       = 1'b1;
        bus.call_ret_i   = 32'h900;
        bus.ret_i        = 1'b1;
        bus.ret_target_i = 32'h7000;
        cyc();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h500 || bus.ras_count_o !== 3'd1) begin
            errors++; $display("FAIL callret_same got pc=%h cnt=%0d want pc=500 cnt=1", bus.pc_o, bus.ras_count_o);
        end
        bus.ret_i        = 1'b1;
        bus.ret_target_i = 32'h7000;
        cyc();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h900 || bus.ras_count_o !== 3'd0) begin
            errors++; $display("FAIL callret_newtop got pc=%h cnt=%0d want pc=900 cnt=0", bus.pc_o, bus.ras_count_o);
        end
    endtask

    task automatic test_wrong_path();
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'h1000;
        bus.call_i        = 1'b1;
        bus.call_ret_i    = 32'hA00;
        cyc();
        clear_inputs();
        bus.branch_i        = 1'b1;
        bus.branch_target_i = 32'h800;
        bus.call_i          = 1'b1;
        bus.call_ret_i      = 32'hB00;
        cyc();
        clear_inputs();
        checks++;
        if (bus.ras_count_o !== 3'd1) begin errors++; $display("FAIL br_call_count got %0d want 1", bus.ras_count_o); end
        bus.branch_i        = 1'b1;
        bus.branch_target_i = 32'h820;
        bus.ret_i           = 1'b1;
        cyc();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h820 || bus.ras_count_o !== 3'd1) begin
            errors++; $display("FAIL br_ret got pc=%h cnt=%0d want pc=820 cnt=1", bus.pc_o, bus.ras_count_o);
        end
        bus.stall_i    = 1'b1;
        bus.call_i     = 1'b1;
        bus.call_ret_i = 32'hC00;
        cyc();
        clear_inputs();
        checks++;
        if (bus.ras_count_o !== 3'd1) begin errors++; $display("FAIL stall_call_count got %0d want 1", bus.ras_count_o); end
        bus.ret_i = 1'b1;
        cyc();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'hA00) begin errors++; $display("FAIL wrong_path_top got %h want a00", bus.pc_o); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_stall_branch();
        test_exception();
        test_jump_wrap();
        test_ret_priority();
`ifndef PC_RAS_EN
        test_no_ras();
`else
        test_ras_fill();
        test_call_ret_same();
        test_wrong_path();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
